// File: rtl/uart_alu_ctrl.sv
// Frame sequencer between uart_rx, an external combinational ALU and uart_tx.
// Collects A, B and opcode bytes, then sends the ALU result (or an error byte).
module uart_alu_ctrl #(
  parameter int                   NB_DATA  = 8,
  parameter int                   NB_OP    = 6,
  parameter int                   TIMEOUT  = 1000000,
  parameter logic [NB_DATA-1:0]   ERR_CODE = 8'hFF
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_done,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_TX
  } state_t;

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
  endfunction

  state_t             state_q;
  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               timeout_q;
  logic               overrun_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               cnt_expired;

  // Inter-byte counter saturates at its terminal value instead of wrapping.
  always_comb begin
    cnt_expired = (cnt_q == CNT_MAX);
    cnt_d       = cnt_expired ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q    <= S_WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_WAIT_A: begin
          if (i_rx_done) begin
            alu_a_q <= i_rx_data;
            cnt_q   <= '0;
            state_q <= S_WAIT_B;
          end
        end
        S_WAIT_B: begin
          if (i_rx_done) begin
            alu_b_q <= i_rx_data;
            cnt_q   <= '0;
            state_q <= S_WAIT_OP;
          end else if (cnt_expired) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_WAIT_A;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_WAIT_OP: begin
          if (i_rx_done) begin
            alu_op_q <= i_rx_data[NB_OP-1:0];
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_EXEC;
          end else if (cnt_expired) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= S_WAIT_A;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        // ALU has seen the registered operands for a full cycle; latch its answer.
        S_EXEC: begin
          tx_data_q  <= op_valid(alu_op_q) ? i_alu_result : ERR_CODE;
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          state_q <= S_WAIT_TX;
        end
        S_WAIT_TX: begin
          if (i_tx_done) begin
            busy_q  <= 1'b0;
            state_q <= S_WAIT_A;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_WAIT_A;
        end
      endcase
      // Bytes arriving while a result is in flight are dropped, but remembered.
      if (i_rx_done && (state_q inside {S_EXEC, S_SEND, S_WAIT_TX})) begin
        overrun_q <= 1'b1;
      end
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_timeout  = timeout_q;
  assign o_overrun  = overrun_q;

endmodule
